// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the execute-stage multiply/divide controller.
package muldiv_ctrl_pkg;

  // Request opcodes carried on req_op; 6 and 7 are reserved no-ops.
  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MTHI  = 3'd4,
    MD_OP_MTLO  = 3'd5
  } md_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

  // Default multiplier latency (operand-sample edge to mul_res valid).
  localparam int MD_MUL_LAT_DEFAULT = 2;

  // Width of the multiply countdown counter; it must hold MUL_LAT-1.
  function automatic int md_cnt_width(input int mul_lat);
    return (mul_lat > 1) ? $clog2(mul_lat) : 1;
  endfunction

  // Even opcodes of the MULT/DIV pairs are the signed variants.
  function automatic logic md_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for EX: owns HI/LO, drives the external
// pipelined multiplier and iterative divider, and exposes busy for interlocks.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_res,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  output logic        div_cancel,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete
);

  localparam int CW = md_cnt_width(MUL_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] div_x_q, div_x_d;
  logic [31:0] div_y_q, div_y_d;
  logic        div_signed_q, div_signed_d;
  logic        div_start_q, div_start_d;
  logic        div_cancel_q, div_cancel_d;

  md_op_e op;
  logic   accept;

  assign op = md_op_e'(req_op);

  // A flush in the same cycle blocks acceptance so a killed instruction
  // cannot start an operation.
  assign req_ready = (state_q == MD_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != MD_IDLE);

  // The multiplier samples straight from the request so it starts on the
  // accept edge itself; it ignores these lines outside of an accept.
  assign mul_x      = req_x;
  assign mul_y      = req_y;
  assign mul_signed = md_is_signed(req_op);

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign div_x      = div_x_q;
  assign div_y      = div_y_q;
  assign div_signed = div_signed_q;
  assign div_start  = div_start_q;
  assign div_cancel = div_cancel_q;

  // Next-state, HI/LO write and divider control decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_x_d      = div_x_q;
    div_y_d      = div_y_q;
    div_signed_d = div_signed_q;
    div_start_d  = 1'b0;
    div_cancel_d = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          case (op)
            MD_OP_MULT, MD_OP_MULTU: begin
              state_d = MD_MUL;
              cnt_d   = CNT_LOAD;
            end
            MD_OP_DIV, MD_OP_DIVU: begin
              // Operands are held in flops for the whole divide so the
              // divider never sees EX moving on underneath it.
              state_d      = MD_DIV;
              div_x_d      = req_x;
              div_y_d      = req_y;
              div_signed_d = md_is_signed(req_op);
              div_start_d  = 1'b1;
            end
            MD_OP_MTHI: hi_d = req_x;
            MD_OP_MTLO: lo_d = req_x;
            default: ; // reserved opcodes retire as no-ops
          endcase
        end
      end

      MD_MUL: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else if (cnt_q == '0) begin
          // mul_res is valid in the cycle whose ending edge is MUL_LAT
          // edges after the sample edge.
          hi_d    = mul_res[63:32];
          lo_d    = mul_res[31:0];
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      MD_DIV: begin
        // Flush wins over a coincident completion; the divider is told to
        // abandon its work so its next completion is not stale.
        if (flush) begin
          state_d      = MD_IDLE;
          div_cancel_d = 1'b1;
        end else if (div_complete) begin
          hi_d    = div_r;
          lo_d    = div_s;
          state_d = MD_IDLE;
        end
      end

      default: state_d = MD_IDLE;
    endcase
  end

  // State and architectural register update; reset needs no cancel pulse
  // because the divider shares the same reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= MD_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      div_x_q      <= '0;
      div_y_q      <= '0;
      div_signed_q <= 1'b0;
      div_start_q  <= 1'b0;
      div_cancel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_x_q      <= div_x_d;
      div_y_q      <= div_y_d;
      div_signed_q <= div_signed_d;
      div_start_q  <= div_start_d;
      div_cancel_q <= div_cancel_d;
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences the shared multiply/divide resources for the execute stage and owns the architectural HI/LO registers.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time over a valid/ready handshake.
- Drives the pipelined multiplier and the iterative divider, and writes their results into HI/LO.
- Exposes busy so MFHI/MFLO/MTHI/MTLO interlock in EX, and supports flush on exception commit.

Parameters:
- MUL_LAT, 2, cycles from the multiplier operand-sample edge to mul_res valid (must be >= 1).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  request present from EX
- req_ready  out  1  controller can accept (state IDLE and no flush)
- req_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved
- req_x  in  32  rs operand (dividend/multiplicand/MT data)
- req_y  in  32  rt operand
- flush  in  1  exception/eret commit; kill in-flight op
- busy  out  1  mul/div in flight; HI/LO not yet final
- hi  out  32  HI register
- lo  out  32  LO register
- mul_signed  out  1  to multiplier
- mul_x  out  32  to multiplier
- mul_y  out  32  to multiplier
- mul_res  in  64  from multiplier, {hi,lo}
- div_start  out  1  one-cycle start pulse to divider
- div_signed  out  1  to divider
- div_x  out  32  registered dividend, held for the whole DIV
- div_y  out  32  registered divisor, held for the whole DIV
- div_cancel  out  1  one-cycle abort pulse to divider
- div_s  in  32  quotient
- div_r  in  32  remainder
- div_complete  in  1  one-cycle done pulse from divider

Behaviour:
- Reset (resetn=0 at edge): state=IDLE, hi=lo=0, cnt=0, busy=0, div_start=0, div_cancel=0, div_x=div_y=0, signed regs=0.
- States:
  - IDLE: req_ready=1 unless flush.
  - MUL: cnt counts down from MUL_LAT-1.
  - DIV: waits for div_complete.
- Accept = req_valid && req_ready, sampled at the edge.
- MULT/MULTU:
  - mul_x/mul_y/mul_signed are combinational from req_x/req_y/req_op[0]==0, so the multiplier samples them on the accept edge.
  - Enter MUL.
  - HI/LO <= mul_res on the edge ending the cycle where cnt==0, i.e. MUL_LAT cycles after accept.
  - Return to IDLE on that same edge.
- DIV/DIVU:
  - On the accept edge: latch div_x, div_y, div_signed; assert div_start for the next cycle only; enter DIV.
  - On div_complete in DIV: hi<=div_r, lo<=div_s, go to IDLE.
  - Divide-by-zero: HI/LO take whatever the divider returns; no exception.
- MTHI/MTLO: hi (or lo) <= req_x on the accept edge; state stays IDLE; busy never rises.
- busy=1 exactly while state is MUL or DIV (registered). With MUL_LAT=2, busy is high for 2 cycles after accept.
- flush:
  - In MUL: drop to IDLE; HI/LO are not written.
  - In DIV: drop to IDLE and pulse div_cancel for one cycle; HI/LO are not written.
  - A flush in the same cycle as req_valid blocks acceptance.
  - A flush in the same cycle as div_complete or the cnt==0 write wins: no write.
- div_complete while not in DIV (stale) is ignored.
- Reserved req_op: accepted as a no-op; no state change.
- Reset mid-operation: returns to IDLE immediately; no div_cancel pulse is issued (the divider resets on the same resetn).
- No back-to-back overlap: a new request is only accepted in IDLE. Earliest next accept is the cycle after a MUL/DIV write edge.

Decomposition:
- Shared package/header (common.vh): MD_OP_* encodings, state encodings (MD_IDLE/MD_MUL/MD_DIV), default MUL_LAT.
- No sub-module. The multiplier and divider stay external and are instantiated alongside this controller in the execute stage.

Test Plan:
- MULT x=0xFFFFFFFE(-2), y=3, MUL_LAT=2 -> busy high 2 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; req_ready returns 1 the cycle after the write.
- MULTU x=0xFFFFFFFF, y=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV x=-7, y=2 with a divider model completing 33 cycles after div_start -> single div_start pulse; div_x/div_y held throughout; hi=0xFFFFFFFF, lo=0xFFFFFFFD; busy drops the cycle after div_complete.
- DIVU in flight, flush at cycle 10 -> div_cancel pulses once, state IDLE, HI/LO keep their prior values (e.g. 0x12345678/0x9ABCDEF0); a late div_complete is ignored.
- MTHI 0xDEADBEEF then MTLO 0xCAFEF00D on consecutive cycles -> both accepted with no busy; hi/lo updated one edge after each.
- req_valid with flush in the same cycle -> not accepted, no state change. Assert resetn=0 during MUL -> hi=lo=0, busy=0 next cycle.
